// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
// Holds the FSM encoding, iteration geometry and the Booth recoding table.
package seq_mul_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 16;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } booth_sel_e;

  // Bit-pair recoding of {Q[2i+1], Q[2i], Q[2i-1]}.
  function automatic booth_sel_e booth_decode(input logic [2:0] bits);
    booth_decode = ZERO;
    case (bits)
      3'b001, 3'b010: booth_decode = PM;
      3'b011:         booth_decode = P2M;
      3'b100:         booth_decode = N2M;
      3'b101, 3'b110: booth_decode = NM;
      default:        booth_decode = ZERO;
    endcase
  endfunction

endpackage

// File: rtl/seq_mul_booth_pp_sel.sv
// Combinational Booth recoder and multiplicand mux.
// Produces the unshifted, sign-extended 2W-bit partial product for one bit-pair.
module booth_pp_sel
  import seq_mul_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]     triplet_i,
  input  logic [W-1:0]   mcand_i,
  output logic [2*W-1:0] pp_o
);

  localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};

  booth_sel_e     sel;
  logic [2*W-1:0] m_ext;
  logic [2*W-1:0] m2_ext;

  assign sel    = booth_decode(triplet_i);
  assign m_ext  = {{W{mcand_i[W-1]}}, mcand_i};
  assign m2_ext = {m_ext[2*W-2:0], 1'b0};

  // Negation is done at full 2W width, so the most negative multiplicand needs no special case.
  always_comb begin
    pp_o = '0;
    case (sel)
      PM:      pp_o = m_ext;
      P2M:     pp_o = m2_ext;
      NM:      pp_o = ~m_ext + ONE;
      N2M:     pp_o = ~m2_ext + ONE;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/seq_mul.sv
// Signed WIDTH x WIDTH sequential multiplier, radix-4 Booth, one bit-pair per cycle.
// Fixed 18-cycle turnaround: launch edge, 16 RUN edges, one DONE cycle.
module seq_mul #(
  parameter int WIDTH = seq_mul_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import seq_mul_pkg::*;

  localparam int IDX_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     q_ext;
  logic [IDX_W-1:0]   pair_idx;
  logic [2:0]         triplet;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] pp_shifted;
  logic [2*WIDTH-1:0] acc_sum;

  // The appended zero is the implicit Q[-1] used by the first bit-pair.
  assign q_ext    = {q_q, 1'b0};
  assign pair_idx = IDX_W'({cnt_q, 1'b0});
  assign triplet  = q_ext[pair_idx +: 3];

  booth_pp_sel #(
    .W(WIDTH)
  ) u_pp_sel (
    .triplet_i(triplet),
    .mcand_i  (m_q),
    .pp_o     (pp)
  );

  assign pp_shifted = pp << pair_idx;
  assign acc_sum    = acc_q + pp_shifted;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    q_d     = q_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          m_d     = M;
          q_d     = Q;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
          hi_d    = acc_sum[2*WIDTH-1:WIDTH];
          lo_d    = acc_sum[WIDTH-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      q_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      q_q     <= q_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_seq_mul.sv
// Directed bench for seq_mul: reset, Booth patterns, start filtering, back-to-back and abort.
module tb_seq_mul;

  logic        clock   = 1'b0;
  logic        clear_n = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] M       = '0;
  logic [31:0] Q       = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  seq_mul #(.WIDTH(32)) dut (
    .clock  (clock),
    .clear_n(clear_n),
    .start  (start),
    .M      (M),
    .Q      (Q),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launches one operation from IDLE and returns edges from launch to done (-1 on timeout).
  task automatic launch(input logic [31:0] m, input logic [31:0] q, output int lat);
    M = m;
    Q = q;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_flags: busy/done got %b, expected 00", {busy, done});
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_result: got %h, expected 0", {hi, lo});
    end
    tick();
    tick();
    clear_n = 1'b1;
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle: busy/done got %b, expected 00", {busy, done});
    end
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    int lat;
    M = 32'd7;
    Q = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_run_flags: busy/done got %b, expected 10", {busy, done});
    end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    n_cmp++;
    if (lat !== 16) begin
      n_err++;
      $display("FAIL basic_latency: got %0d, expected 16", lat);
    end
    n_cmp++;
    if ({hi, lo} !== 64'h0000_0000_0000_002A || busy !== 1'b1) begin
      n_err++;
      $display("FAIL basic_result: got %h busy %b, expected 000000000000002a busy 1", {hi, lo}, busy);
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00 || lo !== 32'h2A) begin
      n_err++;
      $display("FAIL basic_hold: busy/done %b lo %h, expected 00 lo 0000002a", {busy, done}, lo);
    end
    $display("test_basic: 7*6 latency %0d result %h", lat, {hi, lo});
  endtask

  task automatic test_patterns();
    logic [31:0] m_tab  [7] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFB,
                                32'h1234_5678, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] q_tab  [7] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0123,
                                32'hFFFF_FFFE, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [63:0] exp_tab[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000,
                                64'hC000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FA51,
                                64'hFFFF_FFFF_DB97_5310, 64'h0000_0001_0000_0000,
                                64'h0000_0000_0000_0001};
    int lat;
    for (int i = 0; i < 7; i++) begin
      launch(m_tab[i], q_tab[i], lat);
      n_cmp++;
      if (lat !== 16) begin
        n_err++;
        $display("FAIL pattern%0d_latency: got %0d, expected 16", i, lat);
      end
      n_cmp++;
      if ({hi, lo} !== exp_tab[i]) begin
        n_err++;
        $display("FAIL pattern%0d_product: %h*%h got %h, expected %h",
                 i, m_tab[i], q_tab[i], {hi, lo}, exp_tab[i]);
      end
      $display("test_patterns: %h * %h -> %h", m_tab[i], q_tab[i], {hi, lo});
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int at = -1;
    logic [63:0] res = '0;
    M = 32'd7;
    Q = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        start = 1'b1;
        M = 32'd3;
        Q = 32'd3;
      end else if (k == 6) begin
        start = 1'b0;
        M = 32'd9;
        Q = 32'd11;
      end
      tick();
      if (done) begin
        pulses++;
        at = k;
        res = {hi, lo};
      end
    end
    n_cmp++;
    if (pulses !== 1 || at !== 16) begin
      n_err++;
      $display("FAIL ignore_pulses: got %0d pulses at %0d, expected 1 at 16", pulses, at);
    end
    n_cmp++;
    if (res !== 64'h2A) begin
      n_err++;
      $display("FAIL ignore_result: got %h, expected 000000000000002a", res);
    end
    $display("test_ignore_start: pulses %0d result %h", pulses, res);
  endtask

  task automatic test_back_to_back();
    int lat1 = -1;
    int lat2 = -1;
    M = 32'd7;
    Q = 32'd6;
    start = 1'b1;
    tick();
    M = 32'd3;
    Q = 32'd5;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat1 = k;
        break;
      end
    end
    n_cmp++;
    if (lat1 !== 16 || {hi, lo} !== 64'h2A) begin
      n_err++;
      $display("FAIL b2b_first: latency %0d result %h, expected 16 and 000000000000002a", lat1, {hi, lo});
    end
    tick();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_done_ignores_start: busy/done got %b, expected 00", {busy, done});
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({busy, done} !== 2'b10) begin
      n_err++;
      $display("FAIL b2b_relaunch: busy/done got %b, expected 10", {busy, done});
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat2 = k;
        break;
      end
    end
    n_cmp++;
    if (lat1 + 2 + lat2 !== 34 || {hi, lo} !== 64'hF) begin
      n_err++;
      $display("FAIL b2b_second: done spacing %0d result %h, expected 18 and 000000000000000f",
               2 + lat2, {hi, lo});
    end
    $display("test_back_to_back: spacing %0d result %h", 2 + lat2, {hi, lo});
    tick();
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat;
    M = 32'd7;
    Q = 32'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    clear_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
      n_err++;
      $display("FAIL abort_immediate: busy/done %b result %h, expected 00 and 0", {busy, done}, {hi, lo});
    end
    tick();
    tick();
    clear_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (done) pulses++;
      tick();
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d pulses, expected 0", pulses);
    end
    launch(32'd2, 32'd3, lat);
    n_cmp++;
    if (lat !== 16 || {hi, lo} !== 64'h6) begin
      n_err++;
      $display("FAIL abort_restart: latency %0d result %h, expected 16 and 0000000000000006", lat, {hi, lo});
    end
    $display("test_reset_abort: restart latency %0d result %h", lat, {hi, lo});
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
